// File: rtl/axis_pkt_checker.sv
// Receive-side checker for generator frames: a header beat followed by payload beats numbered base+k.
// Validates length, keep, header length/flow fields and payload sequence; keeps statistics and a throughput log.
module axis_pkt_checker #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int EXPECT_BEATS    = 23,
  parameter int FLOW_NUM        = 3,
  parameter int LOG_INTERVAL    = 4096,
  parameter int CNT_WIDTH       = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          clr,
  input  logic                          stall,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic [CNT_WIDTH-1:0]          byte_count,
  output logic [CNT_WIDTH-1:0]          err_count,
  output logic [FLOW_NUM*CNT_WIDTH-1:0] flow_pkt_count,
  output logic [4:0]                    err_flags,
  output logic                          err_pulse,
  output logic                          log_valid,
  output logic [CNT_WIDTH-1:0]          log_bytes
);

  // state | meaning
  // HDR   | waiting for header beat (length and flow fields)
  // SEQ   | first payload beat, latches sequence base
  // BODY  | payload beats checked against base+beat_idx
  // DRAIN | frame overran its length; consume until tlast
  typedef enum logic [1:0] {S_HDR, S_SEQ, S_BODY, S_DRAIN} state_t;

  localparam int IDX_W       = $clog2(EXPECT_BEATS + 1);
  localparam int BYTES_W     = $clog2(AXIS_KEEP_WIDTH + 1);
  localparam int CYC_W       = $clog2(LOG_INTERVAL);
  localparam int HDR_LEN_EXP = EXPECT_BEATS * 64 - 14;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [63:0]          base_q, base_d;
  logic [7:0]           flow_q, flow_d;
  logic [4:0]           frame_err_q, frame_err_d;
  logic [4:0]           beat_err, frame_err_all;
  logic [CNT_WIDTH-1:0] pkt_q, byte_q, err_cnt_q, log_bytes_q, win_q;
  logic [CNT_WIDTH-1:0] flow_cnt_q [FLOW_NUM];
  logic [4:0]           err_flags_q;
  logic                 err_pulse_q, log_valid_q;
  logic [CYC_W-1:0]     cyc_q;

  logic                 beat, close, keep_full;
  logic [7:0]           flow_id_w, cur_flow;
  logic [15:0]          hdr_len_w;
  logic [BYTES_W-1:0]   beat_bytes;
  logic [CNT_WIDTH-1:0] bb;

  function automatic logic [BYTES_W-1:0] popcnt(input logic [AXIS_KEEP_WIDTH-1:0] k);
    logic [BYTES_W-1:0] c;
    c = '0;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++) c = c + BYTES_W'(k[i]);
    return c;
  endfunction

  assign s_axis_tready = ~stall & ~rst;
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign close         = beat & s_axis_tlast;
  assign keep_full     = &s_axis_tkeep;
  assign flow_id_w     = s_axis_tdata[35*8 +: 8];
  assign hdr_len_w     = {s_axis_tdata[16*8 +: 8], s_axis_tdata[17*8 +: 8]};
  assign beat_bytes    = popcnt(s_axis_tkeep);
  assign bb            = beat ? CNT_WIDTH'(beat_bytes) : '0;
  assign cur_flow      = (state_q == S_HDR) ? flow_id_w : flow_q;

  always_comb begin
    beat_err = '0;
    state_d  = state_q;
    idx_d    = idx_q;
    base_d   = base_q;
    flow_d   = flow_q;
    if (beat) begin
      case (state_q)
        S_HDR: begin
          beat_err[0] = ~keep_full;
          beat_err[3] = (hdr_len_w != 16'(HDR_LEN_EXP));
          beat_err[4] = (flow_id_w >= 8'(FLOW_NUM));
          flow_d      = flow_id_w;
          if (s_axis_tlast) begin
            beat_err[1] = 1'b1;
          end else begin
            state_d = S_SEQ;
            idx_d   = IDX_W'(1);
          end
        end
        S_SEQ: begin
          beat_err[0] = ~keep_full;
          base_d      = s_axis_tdata[63:0] - 64'd1;
          if (s_axis_tlast) begin
            beat_err[1] = 1'b1;
            state_d     = S_HDR;
          end else begin
            state_d = S_BODY;
            idx_d   = IDX_W'(2);
          end
        end
        S_BODY: begin
          beat_err[0] = ~keep_full;
          beat_err[2] = (s_axis_tdata[63:0] != base_q + 64'(idx_q)) |
                        (|s_axis_tdata[AXIS_DATA_WIDTH-1:64]);
          if (s_axis_tlast) begin
            beat_err[1] = (idx_q != IDX_W'(EXPECT_BEATS - 1));
            state_d     = S_HDR;
          end else begin
            // overrun is flagged once, then the rest of the frame is drained unchecked
            if (idx_q == IDX_W'(EXPECT_BEATS - 1)) begin
              beat_err[1] = 1'b1;
              state_d     = S_DRAIN;
            end
            idx_d = (idx_q == IDX_W'(EXPECT_BEATS)) ? idx_q : idx_q + IDX_W'(1);
          end
        end
        default: begin
          if (s_axis_tlast) state_d = S_HDR;
        end
      endcase
      if (s_axis_tlast) idx_d = '0;
    end
    frame_err_all = frame_err_q | beat_err;
    frame_err_d   = close ? 5'd0 : frame_err_all;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HDR;
      idx_q       <= '0;
      base_q      <= '0;
      flow_q      <= '0;
      frame_err_q <= '0;
      pkt_q       <= '0;
      byte_q      <= '0;
      err_cnt_q   <= '0;
      err_flags_q <= '0;
      err_pulse_q <= 1'b0;
      log_valid_q <= 1'b0;
      log_bytes_q <= '0;
      win_q       <= '0;
      cyc_q       <= '0;
      for (int i = 0; i < FLOW_NUM; i++) flow_cnt_q[i] <= '0;
    end else if (clr) begin
      state_q     <= S_HDR;
      idx_q       <= '0;
      frame_err_q <= '0;
      pkt_q       <= '0;
      byte_q      <= '0;
      err_cnt_q   <= '0;
      err_flags_q <= '0;
      err_pulse_q <= 1'b0;
      log_valid_q <= 1'b0;
      log_bytes_q <= '0;
      win_q       <= '0;
      cyc_q       <= '0;
      for (int i = 0; i < FLOW_NUM; i++) flow_cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      flow_q      <= flow_d;
      frame_err_q <= frame_err_d;
      byte_q      <= byte_q + bb;
      err_flags_q <= err_flags_q | beat_err;
      err_pulse_q <= close & (|frame_err_all);
      if (close) begin
        pkt_q <= pkt_q + 1'b1;
        if (|frame_err_all) err_cnt_q <= err_cnt_q + 1'b1;
        for (int i = 0; i < FLOW_NUM; i++)
          if (cur_flow == 8'(i)) flow_cnt_q[i] <= flow_cnt_q[i] + 1'b1;
      end
      // window accumulation runs regardless of en; only the cycle count is gated
      log_valid_q <= 1'b0;
      if (en && cyc_q == CYC_W'(LOG_INTERVAL - 1)) begin
        log_bytes_q <= win_q + bb;
        log_valid_q <= 1'b1;
        win_q       <= '0;
        cyc_q       <= '0;
      end else begin
        win_q <= win_q + bb;
        if (en) cyc_q <= cyc_q + 1'b1;
      end
    end
  end

  assign pkt_count  = pkt_q;
  assign byte_count = byte_q;
  assign err_count  = err_cnt_q;
  assign err_flags  = err_flags_q;
  assign err_pulse  = err_pulse_q;
  assign log_valid  = log_valid_q;
  assign log_bytes  = log_bytes_q;

  for (genvar g = 0; g < FLOW_NUM; g++) begin : g_flow
    assign flow_pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = flow_cnt_q[g];
  end

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Directed bench for axis_pkt_checker: frames are generated with a bench-side model of expected
// counters; per-frame error expectations are queued and matched against err_pulse at frame close.
module tb_axis_pkt_checker;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int CW = 64;
  localparam int FN = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, clr = 1'b0, stall = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [CW-1:0] pkt_count, byte_count, err_count, log_bytes;
  logic [FN*CW-1:0] flow_pkt_count;
  logic [4:0]    err_flags;
  logic          err_pulse, log_valid;

  axis_pkt_checker #(
    .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .EXPECT_BEATS(23),
    .FLOW_NUM(FN), .LOG_INTERVAL(64), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .stall(stall),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .pkt_count(pkt_count), .byte_count(byte_count), .err_count(err_count),
    .flow_pkt_count(flow_pkt_count), .err_flags(err_flags), .err_pulse(err_pulse),
    .log_valid(log_valid), .log_bytes(log_bytes)
  );

  always #5 clk = ~clk;

  typedef struct { bit err; int flow; } exp_t;
  exp_t sb_q[$];

  int          n_cmp = 0, n_fail = 0;
  longint unsigned m_pkt, m_bytes, m_err;
  longint unsigned m_flow [FN];
  logic [4:0]  m_flags;
  bit          stall_mode = 0;
  int          tick = 0;
  int          log_seen = 0;
  logic [CW-1:0] exp_log = '0;
  logic [CW-1:0] prev_pkt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    m_pkt = 0; m_bytes = 0; m_err = 0; m_flags = '0;
    for (int i = 0; i < FN; i++) m_flow[i] = 0;
  endtask

  task automatic check_all();
    chk("pkt_count", pkt_count, m_pkt);
    chk("byte_count", byte_count, m_bytes);
    chk("err_count", err_count, m_err);
    chk("err_flags", 64'(err_flags), 64'(m_flags));
    for (int i = 0; i < FN; i++) chk($sformatf("flow%0d_count", i), flow_pkt_count[i*CW +: CW], m_flow[i]);
  endtask

  // scoreboard and log monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      prev_pkt = pkt_count;
    end else begin
      if (pkt_count == prev_pkt + 1) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_fail++;
          $error("FAIL sb_underflow: frame close %0d with empty queue, required none", pkt_count);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk($sformatf("err_pulse_flow%0d", e.flow), 64'(err_pulse), 64'(e.err));
        end
      end else if (err_pulse) begin
        chk("stray_err_pulse", 64'(err_pulse), 64'd0);
      end
      prev_pkt = pkt_count;
      if (log_valid) begin
        log_seen++;
        chk("log_bytes", log_bytes, exp_log);
      end
    end
  end

  task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit last);
    logic acc;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = last; s_axis_tvalid = 1'b1;
    for (int n = 0; ; n++) begin
      stall = stall_mode ? ((tick % 4) == 3) : 1'b0;
      tick++;
      @(posedge clk);
      acc = s_axis_tready;
      #1;
      if (acc) break;
      if (n >= 50) begin
        $display("FAIL beat_timeout: tready low for %0d cycles, required acceptance", n);
        $fatal(1, "beat never accepted");
      end
    end
  endtask

  task automatic send_frame(input int flow, input longint unsigned base, input logic [15:0] hlen,
                            input int nbeats, input int bad_pay, input int bad_keep);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [4:0]    f;
    exp_t          e;
    f    = '0;
    f[0] = (bad_keep >= 0 && bad_keep < nbeats && bad_keep < 23);
    f[1] = (nbeats != 23);
    f[2] = (bad_pay >= 2 && bad_pay < nbeats && bad_pay < 23);
    f[3] = (hlen != 16'd1458);
    f[4] = (flow >= FN);
    e.err = |f; e.flow = flow;
    sb_q.push_back(e);
    m_pkt++;
    m_bytes += longint'(nbeats * 64 - (f[0] ? 4 : 0));
    if (|f) m_err++;
    m_flags |= f;
    if (flow < FN) m_flow[flow]++;
    for (int i = 0; i < nbeats; i++) begin
      d = '0;
      if (i == 0) begin
        d[16*8 +: 8] = hlen[15:8];
        d[17*8 +: 8] = hlen[7:0];
        d[35*8 +: 8] = 8'(flow);
      end else begin
        d[63:0] = base + 64'(i) - 64'd1 + ((i == bad_pay) ? 64'd2 : 64'd0);
      end
      k = (i == bad_keep) ? 64'h0FFF_FFFF_FFFF_FFFF : '1;
      drive_beat(d, k, (i == nbeats - 1));
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_partial(input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = '0;
      if (i == 0) d[16*8 +: 16] = 16'hB205;
      else d[63:0] = 64'(100 + i - 1);
      drive_beat(d, '1, 1'b0);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_zero();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    model_zero();
    #8;
    chk("reset_tready", 64'(s_axis_tready), 64'd0);
    chk("reset_err_pulse", 64'(err_pulse), 64'd0);
    chk("reset_log_valid", 64'(log_valid), 64'd0);
    chk("reset_log_bytes", log_bytes, 64'd0);
    check_all();
    #15 rst = 1'b0;
    @(posedge clk); #1;

    // ten good frames, flows rotating
    for (int i = 0; i < 10; i++) send_frame(i % 3, longint'(i + 1), 16'd1458, 23, -1, -1);
    idle(3);
    check_all();
    chk("t1_bytes_const", byte_count, 64'd14720);
    chk("t1_flow0_const", flow_pkt_count[0 +: CW], 64'd4);

    do_clr();
    check_all();

    // short frame then a clean one
    send_frame(0, 20, 16'd1458, 21, -1, -1);
    send_frame(1, 30, 16'd1458, 23, -1, -1);
    idle(3);
    check_all();
    chk("t2_flags_const", 64'(err_flags), 64'h2);

    do_clr();
    // payload sequence break, then an out-of-range flow id
    send_frame(2, 40, 16'd1458, 23, 5, -1);
    idle(2);
    check_all();
    send_frame(7, 50, 16'd1458, 23, -1, -1);
    idle(3);
    check_all();

    do_clr();
    // bad header length, then partial keep on beat 3
    send_frame(1, 60, 16'h0100, 23, -1, -1);
    idle(2);
    check_all();
    send_frame(2, 70, 16'd1458, 23, -1, 3);
    idle(3);
    check_all();

    do_clr();
    // overlong frame: length flagged once, extra beats drained
    send_frame(0, 80, 16'd1458, 25, -1, -1);
    idle(3);
    check_all();

    do_clr();
    // throughput windows under periodic backpressure
    exp_log = 64'd3072; log_seen = 0; tick = 0; stall_mode = 1; en = 1'b1;
    for (int i = 0; i < 10; i++) send_frame(i % 3, longint'(i + 1), 16'd1458, 23, -1, -1);
    en = 1'b0; stall_mode = 0; stall = 1'b0;
    idle(3);
    chk("log_windows", 64'(log_seen), 64'd4);
    check_all();

    do_clr();
    // async reset mid-frame discards the partial frame
    send_partial(10);
    #2 rst = 1'b1;
    #10;
    chk("midrst_pkt", pkt_count, 64'd0);
    chk("midrst_bytes", byte_count, 64'd0);
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    model_zero();
    @(posedge clk); #1;
    send_frame(1, 90, 16'd1458, 23, -1, -1);
    idle(3);
    check_all();

    // clr mid-frame with a beat presented in the same cycle
    send_partial(5);
    s_axis_tdata = '0; s_axis_tdata[63:0] = 64'd104; s_axis_tkeep = '1; s_axis_tvalid = 1'b1;
    do_clr();
    s_axis_tvalid = 1'b0;
    idle(1);
    check_all();
    chk("clr_log_bytes", log_bytes, 64'd0);
    send_frame(2, 5, 16'd1458, 23, -1, -1);
    idle(3);
    check_all();

    chk("sb_left", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
